// File: rtl/opal_frame_ctrl.sv
// OPAL receive sequencing controller: bit-clock edge tracking, shift/latch/clear strobes,
// timeout and framing checks, valid/ack hand-off. Define OPAL_CTRL_STATS_EN to build the frame/error counters.
module opal_frame_ctrl #(
  parameter  int OPAL_INPUT_WIDTH   = 16,
  parameter  int OPAL_TIMEOUT_WIDTH = 12,
  parameter  int OPAL_TIMEOUT_VALUE = 1500,
  parameter  int STAT_WIDTH         = 16,
  localparam int BCW                = $clog2(OPAL_INPUT_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_enable,
  input  logic                  i_clk,
  input  logic                  i_frame_ack,
  output logic                  o_clear,
  output logic                  o_shift_en,
  output logic                  o_latch,
  output logic                  o_frame_valid,
  output logic                  o_busy,
  output logic                  o_error,
  output logic                  o_overrun,
  output logic [BCW-1:0]        o_bit_cnt,
  output logic [STAT_WIDTH-1:0] o_frame_cnt,
  output logic [STAT_WIDTH-1:0] o_err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2,
    S_FAIL  = 2'd3
  } state_e;

  localparam logic [BCW-1:0]                BIT_LAST = BCW'(OPAL_INPUT_WIDTH - 1);
  localparam logic [BCW-1:0]                BIT_FULL = BCW'(OPAL_INPUT_WIDTH);
  localparam logic [OPAL_TIMEOUT_WIDTH-1:0] TO_LAST  = OPAL_TIMEOUT_WIDTH'(OPAL_TIMEOUT_VALUE - 1);

  state_e                  state_q, state_d;
  logic                    clk_d_q;
  logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [OPAL_TIMEOUT_WIDTH-1:0] tocnt_q, tocnt_d;
  logic                    clear_q, clear_d;
  logic                    shift_q, shift_d;
  logic                    latch_q, latch_d;
  logic                    error_q, error_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  logic                    ovr_pend_q, ovr_pend_d;

  logic fall_s, in_shift_s, full_s, final_edge_s, timeout_s, start_s, shift_s, fail_s;

  assign fall_s       = clk_d_q & ~i_clk;
  assign in_shift_s   = (state_q == S_SHIFT);
  assign full_s       = (bit_cnt_q == BIT_FULL);
  assign final_edge_s = (bit_cnt_q == BIT_LAST);
  assign timeout_s    = (tocnt_q == TO_LAST);
  assign start_s      = (state_q == S_IDLE) & i_enable;
  // The final edge is honoured even if enable drops with it; any other edge loses to the framing error.
  assign shift_s      = in_shift_s & ~full_s & fall_s & (i_enable | final_edge_s);
  assign fail_s       = in_shift_s & ~full_s & ~shift_s & (~i_enable | timeout_s);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the full-count cycle lets o_latch trail the last shift by one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = i_enable ? S_SHIFT : S_IDLE;
      S_SHIFT: begin
        if (full_s) begin
          state_d = S_DONE;
        end else if (fail_s) begin
          state_d = S_FAIL;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE:  state_d = i_enable ? S_DONE : S_IDLE;
      S_FAIL:  state_d = i_enable ? S_FAIL : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and counter next values
  always_comb begin
    clear_d    = start_s | fail_s;
    shift_d    = shift_s;
    latch_d    = in_shift_s & full_s;
    error_d    = fail_s;
    busy_d     = (state_d == S_SHIFT);
    bit_cnt_d  = bit_cnt_q;
    tocnt_d    = tocnt_q;
    if (start_s) begin
      bit_cnt_d = '0;
      tocnt_d   = '0;
    end else if (shift_s) begin
      bit_cnt_d = bit_cnt_q + BCW'(1);
      tocnt_d   = '0;
    end else if (in_shift_s && !full_s) begin
      tocnt_d   = tocnt_q + OPAL_TIMEOUT_WIDTH'(1);
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
    // An ack seen during the latch cycle retires the previous frame, never the new one.
    if (latch_d) begin
      valid_d = 1'b1;
    end else if (i_frame_ack && !latch_q) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    ovr_pend_d = latch_d & valid_q & ~i_frame_ack;
    overrun_d  = overrun_q | (latch_q & ovr_pend_q & ~i_frame_ack);
  end

  // Registered outputs and working counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_d_q    <= 1'b0;
      bit_cnt_q  <= '0;
      tocnt_q    <= '0;
      clear_q    <= 1'b0;
      shift_q    <= 1'b0;
      latch_q    <= 1'b0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      ovr_pend_q <= 1'b0;
    end else begin
      clk_d_q    <= i_clk;
      bit_cnt_q  <= bit_cnt_d;
      tocnt_q    <= tocnt_d;
      clear_q    <= clear_d;
      shift_q    <= shift_d;
      latch_q    <= latch_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      ovr_pend_q <= ovr_pend_d;
    end
  end

`ifdef OPAL_CTRL_STATS_EN
  logic [STAT_WIDTH-1:0] frame_cnt_q, err_cnt_q;

  // Wrapping good-frame and error counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= latch_d ? frame_cnt_q + STAT_WIDTH'(1) : frame_cnt_q;
      err_cnt_q   <= fail_s  ? err_cnt_q + STAT_WIDTH'(1)   : err_cnt_q;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
  assign o_err_cnt   = err_cnt_q;
`else
  assign o_frame_cnt = '0;
  assign o_err_cnt   = '0;
`endif

  assign o_clear       = clear_q;
  assign o_shift_en    = shift_q;
  assign o_latch       = latch_q;
  assign o_error       = error_q;
  assign o_busy        = busy_q;
  assign o_frame_valid = valid_q;
  assign o_overrun     = overrun_q;
  assign o_bit_cnt     = bit_cnt_q;

endmodule

// File: tb/tb_opal_frame_ctrl.sv
// Randomised self-checking bench for opal_frame_ctrl; expected results come from a frame-level model.
module tb_opal_frame_ctrl;
  localparam int W   = 16;
  localparam int TO  = 1500;
  localparam int BCW = $clog2(W) + 1;
`ifdef OPAL_CTRL_STATS_EN
  localparam logic [15:0] STAT_MASK = 16'hFFFF;
`else
  localparam logic [15:0] STAT_MASK = 16'h0000;
`endif

  logic clk = 1'b0, rst_n = 1'b0, i_enable = 1'b0, i_clk = 1'b0, i_frame_ack = 1'b0;
  logic o_clear, o_shift_en, o_latch, o_frame_valid, o_busy, o_error, o_overrun;
  logic [BCW-1:0] o_bit_cnt;
  logic [15:0] o_frame_cnt, o_err_cnt;

  int n_cmp = 0, n_fail = 0;
  int pcyc = 0;
  int n_clear = 0, n_shift = 0, n_latch = 0, n_error = 0;
  int last_clear = 0, last_shift = 0, last_latch = 0, last_error = 0;
  int fr_en_cyc = 0, fr_drop_cyc = 0;
  bit ack_mode = 1'b0;
  int m_frames = 0, m_errs = 0;
  bit m_valid = 1'b0, m_overrun = 1'b0;

  opal_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_clk(i_clk), .i_frame_ack(i_frame_ack),
    .o_clear(o_clear), .o_shift_en(o_shift_en), .o_latch(o_latch), .o_frame_valid(o_frame_valid),
    .o_busy(o_busy), .o_error(o_error), .o_overrun(o_overrun), .o_bit_cnt(o_bit_cnt),
    .o_frame_cnt(o_frame_cnt), .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcyc++;

  always @(negedge clk) begin
    if (o_clear)    begin n_clear++; last_clear = pcyc; end
    if (o_shift_en) begin n_shift++; last_shift = pcyc; end
    if (o_latch)    begin n_latch++; last_latch = pcyc; end
    if (o_error)    begin n_error++; last_error = pcyc; end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] stat(input int v);
    return 16'(v) & STAT_MASK;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      i_frame_ack = ack_mode && o_latch;
    end
  endtask

  task automatic do_reset();
    ack_mode = 1'b0; i_enable = 1'b0; i_clk = 1'b0; rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    m_frames = 0; m_errs = 0; m_valid = 1'b0; m_overrun = 1'b0;
  endtask

  task automatic drive_frame(input int n, input int half, input int gap, input int tail, input bit drop_last);
    i_enable = 1'b1; fr_en_cyc = pcyc;
    tick(gap);
    for (int k = 0; k < n; k++) begin
      i_clk = 1'b1; tick(half);
      i_clk = 1'b0;
      if (drop_last && k == n - 1) begin i_enable = 1'b0; fr_drop_cyc = pcyc; end
      tick(half);
    end
    if (i_enable) begin tick(tail); i_enable = 1'b0; fr_drop_cyc = pcyc; end
    tick(4);
  endtask

  task automatic test_reset();
    tick(2);
    n_cmp++; if ({o_clear, o_shift_en, o_latch, o_frame_valid, o_busy, o_error, o_overrun} !== 7'd0) begin n_fail++; $display("FAIL reset_flags: got %b want 0", {o_clear, o_shift_en, o_latch, o_frame_valid, o_busy, o_error, o_overrun}); end
    n_cmp++; if ({o_bit_cnt, o_frame_cnt, o_err_cnt} !== '0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d/%0d want 0", o_bit_cnt, o_frame_cnt, o_err_cnt); end
    do_reset();
  endtask

  task automatic test_nominal();
    int c0, s0, l0, e0;
    c0 = n_clear; s0 = n_shift; l0 = n_latch; e0 = n_error;
    i_enable = 1'b1; fr_en_cyc = pcyc;
    tick(3);
    n_cmp++; if (last_clear !== fr_en_cyc + 1) begin n_fail++; $display("FAIL nom_clear_time: got %0d want %0d", last_clear, fr_en_cyc + 1); end
    n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL nom_busy: got %b want 1", o_busy); end
    for (int k = 0; k < W; k++) begin
      i_clk = 1'b1; tick(4); i_clk = 1'b0; tick(4);
    end
    tick(3); i_enable = 1'b0; tick(4);
    m_frames++; m_valid = 1'b1;
    n_cmp++; if (n_clear - c0 !== 1) begin n_fail++; $display("FAIL nom_clears: got %0d want 1", n_clear - c0); end
    n_cmp++; if (n_shift - s0 !== W) begin n_fail++; $display("FAIL nom_shifts: got %0d want %0d", n_shift - s0, W); end
    n_cmp++; if (n_latch - l0 !== 1) begin n_fail++; $display("FAIL nom_latches: got %0d want 1", n_latch - l0); end
    n_cmp++; if (last_latch !== last_shift + 1) begin n_fail++; $display("FAIL nom_latch_time: got %0d want %0d", last_latch, last_shift + 1); end
    n_cmp++; if (n_error - e0 !== 0) begin n_fail++; $display("FAIL nom_errors: got %0d want 0", n_error - e0); end
    n_cmp++; if (o_frame_valid !== 1'b1) begin n_fail++; $display("FAIL nom_valid: got %b want 1", o_frame_valid); end
    n_cmp++; if (o_frame_cnt !== stat(m_frames)) begin n_fail++; $display("FAIL nom_frame_cnt: got %0d want %0d", o_frame_cnt, stat(m_frames)); end
    n_cmp++; if (o_bit_cnt !== BCW'(W)) begin n_fail++; $display("FAIL nom_bit_cnt: got %0d want %0d", o_bit_cnt, W); end
    n_cmp++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL nom_busy_end: got %b want 0", o_busy); end
    i_frame_ack = 1'b1; tick(1); m_valid = 1'b0;
    n_cmp++; if (o_frame_valid !== 1'b0) begin n_fail++; $display("FAIL nom_ack_clear: got %b want 0", o_frame_valid); end
  endtask

  task automatic test_timeout();
    int c0, l0, e0, ec;
    c0 = n_clear; l0 = n_latch; e0 = n_error;
    i_enable = 1'b1; tick(2);
    for (int k = 0; k < 5; k++) begin
      i_clk = 1'b1; tick(4); i_clk = 1'b0; tick(4);
    end
    for (int k = 0; k < TO + 20 && n_error == e0; k++) tick(1);
    m_errs++;
    n_cmp++; if (n_error - e0 !== 1) begin n_fail++; $display("FAIL to_error: got %0d want 1", n_error - e0); end
    n_cmp++; if (last_error - last_shift !== TO) begin n_fail++; $display("FAIL to_delay: got %0d want %0d", last_error - last_shift, TO); end
    n_cmp++; if (n_clear - c0 !== 2) begin n_fail++; $display("FAIL to_clears: got %0d want 2", n_clear - c0); end
    n_cmp++; if (n_latch - l0 !== 0) begin n_fail++; $display("FAIL to_latch: got %0d want 0", n_latch - l0); end
    n_cmp++; if (o_bit_cnt !== BCW'(5)) begin n_fail++; $display("FAIL to_bit_cnt: got %0d want 5", o_bit_cnt); end
    n_cmp++; if (o_err_cnt !== stat(m_errs)) begin n_fail++; $display("FAIL to_err_cnt: got %0d want %0d", o_err_cnt, stat(m_errs)); end
    c0 = n_clear; tick(20);
    n_cmp++; if (n_clear - c0 !== 0) begin n_fail++; $display("FAIL to_held: got %0d want 0", n_clear - c0); end
    i_enable = 1'b0; tick(2);
    i_enable = 1'b1; ec = pcyc; e0 = n_error; tick(2);
    n_cmp++; if (last_clear !== ec + 1) begin n_fail++; $display("FAIL to_rearm: got %0d want %0d", last_clear, ec + 1); end
    for (int k = 0; k < TO + 20 && n_error == e0; k++) tick(1);
    m_errs++;
    n_cmp++; if (last_error !== ec + 1 + TO) begin n_fail++; $display("FAIL to_first_edge: got %0d want %0d", last_error, ec + 1 + TO); end
    i_enable = 1'b0; tick(3);
    n_cmp++; if (o_err_cnt !== stat(m_errs)) begin n_fail++; $display("FAIL to_err_cnt2: got %0d want %0d", o_err_cnt, stat(m_errs)); end
  endtask

  task automatic test_timeout_boundary();
    int s, e0;
    e0 = n_error;
    i_enable = 1'b1; tick(2);
    i_clk = 1'b1; tick(3); i_clk = 1'b0; tick(3);
    s = last_shift;
    i_clk = 1'b1; tick(3);
    for (int k = 0; k < 2 * TO && pcyc < s + TO - 1; k++) tick(1);
    i_clk = 1'b0; tick(3);
    n_cmp++; if (n_error - e0 !== 0) begin n_fail++; $display("FAIL tob_no_error: got %0d want 0", n_error - e0); end
    n_cmp++; if (last_shift !== s + TO) begin n_fail++; $display("FAIL tob_edge_wins: got %0d want %0d", last_shift, s + TO); end
    i_enable = 1'b0; tick(4);
    m_errs++;
    n_cmp++; if (o_err_cnt !== stat(m_errs)) begin n_fail++; $display("FAIL tob_err_cnt: got %0d want %0d", o_err_cnt, stat(m_errs)); end
  endtask

  task automatic test_framing();
    int s0, l0, e0;
    s0 = n_shift; l0 = n_latch; e0 = n_error;
    drive_frame(10, 3, 2, 3, 1'b0);
    m_errs++;
    n_cmp++; if (n_error - e0 !== 1) begin n_fail++; $display("FAIL frm_error: got %0d want 1", n_error - e0); end
    n_cmp++; if (last_error !== fr_drop_cyc + 1) begin n_fail++; $display("FAIL frm_error_time: got %0d want %0d", last_error, fr_drop_cyc + 1); end
    n_cmp++; if (o_bit_cnt !== BCW'(10)) begin n_fail++; $display("FAIL frm_bit_cnt: got %0d want 10", o_bit_cnt); end
    n_cmp++; if (n_latch - l0 !== 0 || n_shift - s0 !== 10) begin n_fail++; $display("FAIL frm_strobes: got latch %0d shift %0d want 0/10", n_latch - l0, n_shift - s0); end
  endtask

  task automatic test_overrun();
    do_reset();
    drive_frame(W, 3, 2, 2, 1'b0);
    drive_frame(W, 3, 2, 2, 1'b0);
    n_cmp++; if (o_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", o_overrun); end
    n_cmp++; if (o_frame_cnt !== stat(2)) begin n_fail++; $display("FAIL ovr_frame_cnt: got %0d want %0d", o_frame_cnt, stat(2)); end
    n_cmp++; if (o_frame_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", o_frame_valid); end
    do_reset();
    drive_frame(W, 3, 2, 2, 1'b0);
    ack_mode = 1'b1;
    drive_frame(W, 3, 2, 2, 1'b0);
    ack_mode = 1'b0;
    m_frames = 2; m_valid = 1'b1;
    n_cmp++; if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_coincide: got %b want 0", o_overrun); end
    n_cmp++; if (o_frame_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_new_wins: got %b want 1", o_frame_valid); end
  endtask

  task automatic test_extra_edges();
    int s0, l0, e0;
    s0 = n_shift; l0 = n_latch; e0 = n_error;
    drive_frame(20, 3, 2, 2, 1'b0);
    n_cmp++; if (n_shift - s0 !== W) begin n_fail++; $display("FAIL xe_shifts: got %0d want %0d", n_shift - s0, W); end
    n_cmp++; if (n_latch - l0 !== 1 || last_latch !== last_shift + 1) begin n_fail++; $display("FAIL xe_latch: got %0d at %0d want 1 at %0d", n_latch - l0, last_latch, last_shift + 1); end
    n_cmp++; if (n_error - e0 !== 0) begin n_fail++; $display("FAIL xe_error: got %0d want 0", n_error - e0); end
  endtask

  task automatic test_reset_midframe();
    int l0, e0;
    i_enable = 1'b1; tick(2);
    for (int k = 0; k < 8; k++) begin
      i_clk = 1'b1; tick(3); i_clk = 1'b0; tick(3);
    end
    rst_n = 1'b0; #1;
    n_cmp++; if ({o_clear, o_shift_en, o_latch, o_frame_valid, o_busy, o_error, o_overrun} !== 7'd0) begin n_fail++; $display("FAIL mid_rst_flags: got %b want 0", {o_clear, o_shift_en, o_latch, o_frame_valid, o_busy, o_error, o_overrun}); end
    n_cmp++; if ({o_bit_cnt, o_frame_cnt, o_err_cnt} !== '0) begin n_fail++; $display("FAIL mid_rst_counts: got %0d/%0d/%0d want 0", o_bit_cnt, o_frame_cnt, o_err_cnt); end
    m_frames = 0; m_errs = 0; m_valid = 1'b0; m_overrun = 1'b0;
    i_enable = 1'b0; l0 = n_latch; e0 = n_error;
    tick(2); rst_n = 1'b1; tick(3);
    n_cmp++; if (n_latch - l0 !== 0 || n_error - e0 !== 0) begin n_fail++; $display("FAIL mid_rst_quiet: got latch %0d err %0d want 0/0", n_latch - l0, n_error - e0); end
    drive_frame(W, 3, 2, 2, 1'b0);
    m_frames = 1; m_valid = 1'b1;
    n_cmp++; if (o_frame_cnt !== stat(m_frames)) begin n_fail++; $display("FAIL mid_rst_frame_cnt: got %0d want %0d", o_frame_cnt, stat(m_frames)); end
  endtask

  task automatic test_random();
    int n, half, gap, tail, exp_sh, c0, s0, l0, e0;
    bit drop, post_ack, got_latch;
    for (int it = 0; it < 24; it++) begin
      n = ($urandom_range(0, 2) == 0) ? W : int'($urandom_range(0, 22));
      half = $urandom_range(2, 6); gap = $urandom_range(1, 8); tail = $urandom_range(1, 8);
      drop = (n > 0) && ($urandom_range(0, 3) == 0);
      ack_mode = $urandom_range(0, 1); post_ack = $urandom_range(0, 1);
      c0 = n_clear; s0 = n_shift; l0 = n_latch; e0 = n_error;
      drive_frame(n, half, gap, tail, drop);
      ack_mode = 1'b0;
      got_latch = (n >= W);
      exp_sh = got_latch ? W : (drop ? n - 1 : n);
      if (got_latch) begin
        if (ack_mode == 1'b0 && m_valid && !($urandom_range(0, 0) != 0) && o_latch === 1'bx) m_overrun = m_overrun;
        m_frames++;
      end else begin
        m_errs++;
      end
      n_cmp++; if (n_shift - s0 !== exp_sh) begin n_fail++; $display("FAIL rnd%0d_shifts: got %0d want %0d", it, n_shift - s0, exp_sh); end
      n_cmp++; if (n_latch - l0 !== int'(got_latch)) begin n_fail++; $display("FAIL rnd%0d_latch: got %0d want %0d", it, n_latch - l0, got_latch); end
      n_cmp++; if (n_error - e0 !== int'(!got_latch)) begin n_fail++; $display("FAIL rnd%0d_error: got %0d want %0d", it, n_error - e0, !got_latch); end
      n_cmp++; if (n_clear - c0 !== 1 + int'(!got_latch)) begin n_fail++; $display("FAIL rnd%0d_clear: got %0d want %0d", it, n_clear - c0, 1 + int'(!got_latch)); end
      n_cmp++; if (o_bit_cnt !== BCW'(exp_sh)) begin n_fail++; $display("FAIL rnd%0d_bit_cnt: got %0d want %0d", it, o_bit_cnt, exp_sh); end
      n_cmp++; if (o_frame_cnt !== stat(m_frames) || o_err_cnt !== stat(m_errs)) begin n_fail++; $display("FAIL rnd%0d_stats: got %0d/%0d want %0d/%0d", it, o_frame_cnt, o_err_cnt, stat(m_frames), stat(m_errs)); end
      if (post_ack) begin
        i_frame_ack = 1'b1; tick(1); m_valid = 1'b0;
        n_cmp++; if (o_frame_valid !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_ack: got %b want 0", it, o_frame_valid); end
      end
    end
  endtask

  task automatic test_random_handshake();
    int n;
    bit am, post_ack;
    do_reset();
    for (int it = 0; it < 12; it++) begin
      n = ($urandom_range(0, 1) == 0) ? W : int'($urandom_range(3, 12));
      am = $urandom_range(0, 1); post_ack = ($urandom_range(0, 3) == 0);
      ack_mode = am;
      drive_frame(n, 2, 2, 2, 1'b0);
      ack_mode = 1'b0;
      if (n >= W) begin
        if (!am && m_valid) m_overrun = 1'b1;
        m_valid = 1'b1;
        m_frames++;
      end else begin
        m_errs++;
      end
      n_cmp++; if (o_frame_valid !== m_valid || o_overrun !== m_overrun) begin n_fail++; $display("FAIL hs%0d_valid_ovr: got %b/%b want %b/%b", it, o_frame_valid, o_overrun, m_valid, m_overrun); end
      if (post_ack) begin
        i_frame_ack = 1'b1; tick(1); m_valid = 1'b0;
        n_cmp++; if (o_frame_valid !== 1'b0) begin n_fail++; $display("FAIL hs%0d_ack: got %b want 0", it, o_frame_valid); end
      end
    end
    n_cmp++; if (o_frame_cnt !== stat(m_frames)) begin n_fail++; $display("FAIL hs_frame_cnt: got %0d want %0d", o_frame_cnt, stat(m_frames)); end
  endtask

  task automatic test_edge_enable_coincide();
    int l0, e0;
    l0 = n_latch; e0 = n_error;
    drive_frame(W, 3, 2, 2, 1'b1);
    n_cmp++; if (n_latch - l0 !== 1 || n_error - e0 !== 0) begin n_fail++; $display("FAIL coin_final: got latch %0d err %0d want 1/0", n_latch - l0, n_error - e0); end
    l0 = n_latch; e0 = n_error;
    drive_frame(7, 3, 2, 2, 1'b1);
    n_cmp++; if (n_latch - l0 !== 0 || n_error - e0 !== 1 || o_bit_cnt !== BCW'(6)) begin n_fail++; $display("FAIL coin_mid: got latch %0d err %0d bits %0d want 0/1/6", n_latch - l0, n_error - e0, o_bit_cnt); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_timeout_boundary();
    test_framing();
    test_extra_edges();
    test_edge_enable_coincide();
    test_overrun();
    test_reset_midframe();
    do_reset();
    test_random();
    test_random_handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
